serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 169 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b over WIDTH cycles, LSB first, valid/ready on both sides.
// Define SERIAL_SUB_SAT_EN to saturate diff to zero whenever a < b.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_last;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_diff_final;

  // Full-subtractor bit cell: difference and borrow-out of x - y - bin.
  function automatic logic fs_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  assign w_last   = (r_cnt == LAST_BIT);
  assign w_d      = fs_diff(r_sa[0], r_sb[0], r_br);
  assign w_br_nxt = fs_borrow(r_sa[0], r_sb[0], r_br);
  assign w_sr_nxt = {w_d, r_sr[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
  assign w_diff_final = w_br_nxt ? {WIDTH{1'b0}} : w_sr_nxt;
`else
  assign w_diff_final = w_sr_nxt;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; no pipelining, so DONE always returns to IDLE first.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Serial datapath; diff/borrow_out change only on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= {WIDTH{1'b0}};
      r_sb     <= {WIDTH{1'b0}};
      r_sr     <= {WIDTH{1'b0}};
      r_br     <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_diff   <= {WIDTH{1'b0}};
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sr  <= {WIDTH{1'b0}};
            r_br  <= 1'b0;
            r_cnt <= {CW{1'b0}};
          end
        end
        S_BUSY: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_sr  <= w_sr_nxt;
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff   <= w_diff_final;
            r_borrow <= w_br_nxt;
          end
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Table-driven and scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16.
`timescale 1ns/1ps
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] d;
    logic        bo;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv8, ir8, ov8, or8, bo8, busy8;
  logic [7:0] a8, b8, d8;
  logic iv16, ir16, ov16, or16, bo16, busy16;
  logic [15:0] a16, b16, d16;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8), .busy(busy8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .borrow_out(bo16), .busy(busy16)
  );

  int checks = 0;
  int errors = 0;
  int pushed8 = 0, popped8 = 0, pushed16 = 0, popped16 = 0;
  res_t q8[$];
  res_t q16[$];
  logic rand_rdy = 1'b0;
  vec_t tbl[6];

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input int w);
    res_t r;
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r.bo = (x < y);
    r.d  = (x - y) & mask;
    if (SAT && r.bo) r.d = 32'd0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: scoreboard work on the falling edge, then step past the rising edge.
  task automatic tick();
    res_t r;
    @(negedge clk);
    if (rst) begin
      q8.delete();
      q16.delete();
    end else begin
      if (iv8 && ir8) begin q8.push_back(model({24'd0, a8}, {24'd0, b8}, 8)); pushed8++; end
      if (ov8 && or8) begin
        popped8++;
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL w8 spurious result: got diff %0d with empty scoreboard", d8);
        end else begin
          r = q8.pop_front();
          chk("w8 sb diff", {24'd0, d8}, r.d);
          chk("w8 sb borrow", {31'd0, bo8}, {31'd0, r.bo});
        end
      end
      if (iv16 && ir16) begin q16.push_back(model({16'd0, a16}, {16'd0, b16}, 16)); pushed16++; end
      if (ov16 && or16) begin
        popped16++;
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL w16 spurious result: got diff %0d with empty scoreboard", d16);
        end else begin
          r = q16.pop_front();
          chk("w16 sb diff", {16'd0, d16}, r.d);
          chk("w16 sb borrow", {31'd0, bo16}, {31'd0, r.bo});
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      or8  = 1'($urandom_range(0, 1));
      or16 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    iv8 = 1'b1; a8 = x; b8 = y;
    while (!ir8 && n < 200) begin tick(); n++; end
    if (!ir8) begin
      checks++; errors++;
      $display("FAIL w8 in_ready timeout: got 0 expected 1");
    end
    tick();
    iv8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    iv16 = 1'b1; a16 = x; b16 = y;
    while (!ir16 && n < 200) begin tick(); n++; end
    if (!ir16) begin
      checks++; errors++;
      $display("FAIL w16 in_ready timeout: got 0 expected 1");
    end
    tick();
    iv16 = 1'b0;
  endtask

  task automatic wait_out8();
    int n = 0;
    while (!ov8 && n < 200) begin tick(); n++; end
    chk("w8 out_valid wait", {31'd0, ov8}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 2000) begin tick(); n++; end
    chk("w8 queue drained", q8.size(), 32'd0);
    chk("w16 queue drained", q16.size(), 32'd0);
  endtask

  initial begin
    tbl[0] = '{8'd100, 8'd37,  8'd63,                    1'b0};
    tbl[1] = '{8'd37,  8'd100, SAT ? 8'd0 : 8'd193,      1'b1};
    tbl[2] = '{8'd0,   8'd1,   SAT ? 8'd0 : 8'd255,      1'b1};
    tbl[3] = '{8'd255, 8'd255, 8'd0,                     1'b0};
    tbl[4] = '{8'd255, 8'd0,   8'd255,                   1'b0};
    tbl[5] = '{8'd9,   8'd3,   8'd6,                     1'b0};

    rst = 1'b1;
    iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; or8 = 1'b0;
    iv16 = 1'b0; a16 = 16'd0; b16 = 16'd0; or16 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset in_ready", {31'd0, ir8}, 32'd1);
    chk("reset out_valid", {31'd0, ov8}, 32'd0);
    chk("reset diff", {24'd0, d8}, 32'd0);
    chk("reset borrow", {31'd0, bo8}, 32'd0);
    chk("reset busy", {31'd0, busy8}, 32'd0);

    // Latency: accepted at edge N, out_valid after N+8, in_ready after N+9.
    or8 = 1'b1;
    send8(8'd100, 8'd37);
    repeat (7) tick();
    chk("lat out_valid early", {31'd0, ov8}, 32'd0);
    tick();
    chk("lat out_valid", {31'd0, ov8}, 32'd1);
    chk("lat in_ready low", {31'd0, ir8}, 32'd0);
    chk("lat busy", {31'd0, busy8}, 32'd1);
    tick();
    chk("lat in_ready back", {31'd0, ir8}, 32'd1);
    chk("lat out_valid drop", {31'd0, ov8}, 32'd0);
    chk("lat busy drop", {31'd0, busy8}, 32'd0);
    chk("lat diff held", {24'd0, d8}, 32'd63);

    for (int i = 0; i < 6; i++) begin
      send8(tbl[i].a, tbl[i].b);
      wait_out8();
      chk("tbl diff", {24'd0, d8}, {24'd0, tbl[i].ed});
      chk("tbl borrow", {31'd0, bo8}, {31'd0, tbl[i].eb});
      tick();
    end

    // Backpressure: DONE holds, new operands ignored.
    or8 = 1'b0;
    send8(8'd37, 8'd100);
    wait_out8();
    for (int k = 0; k < 10; k++) begin
      iv8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
      tick();
      chk("bp out_valid", {31'd0, ov8}, 32'd1);
      chk("bp in_ready", {31'd0, ir8}, 32'd0);
      chk("bp diff", {24'd0, d8}, SAT ? 32'd0 : 32'd193);
      chk("bp borrow", {31'd0, bo8}, 32'd1);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    tick();
    chk("bp release out_valid", {31'd0, ov8}, 32'd0);
    chk("bp release in_ready", {31'd0, ir8}, 32'd1);

    // Reset mid-operation, then a clean transaction.
    send8(8'd200, 8'd50);
    repeat (4) tick();
    chk("mid busy", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst in_ready", {31'd0, ir8}, 32'd1);
    chk("mid rst out_valid", {31'd0, ov8}, 32'd0);
    chk("mid rst diff", {24'd0, d8}, 32'd0);
    chk("mid rst borrow", {31'd0, bo8}, 32'd0);
    chk("mid rst busy", {31'd0, busy8}, 32'd0);
    send8(8'd9, 8'd3);
    wait_out8();
    chk("post rst diff", {24'd0, d8}, 32'd6);
    chk("post rst borrow", {31'd0, bo8}, 32'd0);
    tick();

    // Random traffic with random backpressure.
    pushed8 = 0; popped8 = 0; pushed16 = 0; popped16 = 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send8(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int i = 0; i < 1000; i++) begin
      send16(16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    chk("w8 pushed count", pushed8, 32'd1000);
    chk("w8 popped count", popped8, 32'd1000);
    chk("w16 pushed count", pushed16, 32'd1000);
    chk("w16 popped count", popped16, 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
